// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel strobe, h/v counters, sync/blank
// with a pixel-tick delay line for DAC pipeline compensation, plus enable/hold and restart.
module vga_timing_gen #(
    parameter  int CLK_DIV  = 4,
    parameter  int H_ACTIVE = 640,
    parameter  int H_FP     = 16,
    parameter  int H_SYNC   = 96,
    parameter  int H_BP     = 48,
    parameter  int V_ACTIVE = 480,
    parameter  int V_FP     = 10,
    parameter  int V_SYNC   = 2,
    parameter  int V_BP     = 33,
    parameter  int HS_POL   = 0,
    parameter  int VS_POL   = 0,
    parameter  int PIPE_DLY = 2,
    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOT),
    localparam int VW       = $clog2(V_TOT)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          en,
    input  logic          restart,
    output logic          pix_tick,
    output logic          h_sync,
    output logic          v_sync,
    output logic          n_blank,
    output logic          n_sync,
    output logic [HW-1:0] hPix,
    output logic [VW-1:0] vPix,
    output logic          active,
    output logic          line_end,
    output logic          frame_end
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DN = (PIPE_DLY > 0) ? PIPE_DLY : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam int HS_BEG = H_ACTIVE + H_FP;
    localparam int HS_END = HS_BEG + H_SYNC;
    localparam int VS_BEG = V_ACTIVE + V_FP;
    localparam int VS_END = VS_BEG + V_SYNC;
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } raster_t;

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          run_q;
    logic          tick, advance, h_wrap;
    raster_t       raw, dly;

    // run_q keeps every output at its idle value until the first clock after reset,
    // even though the counters already sit at the visible position (0,0).
    assign tick    = en & run_q & (div_q == DIV_LAST);
    assign advance = tick & ~restart;
    assign h_wrap  = (h_q == H_LAST);

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no branch can infer a latch.
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (restart) begin
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
        end else if (tick) begin
            div_d = '0;
            h_d   = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else if (en && run_q) begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!n_rst) begin
            run_q <= 1'b0;
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            run_q <= 1'b1;
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    always_comb begin
        raw.act = run_q & (32'(h_q) < H_ACTIVE) & (32'(v_q) < V_ACTIVE);
        raw.hs  = run_q & (32'(h_q) >= HS_BEG) & (32'(h_q) < HS_END);
        raw.vs  = run_q & (32'(v_q) >= VS_BEG) & (32'(v_q) < VS_END);
    end

    generate
        if (PIPE_DLY == 0) begin : g_pass
            assign dly = raw;
        end else begin : g_pipe
            raster_t stage_q [DN];
            always_ff @(posedge clk or negedge n_rst) begin
                // NOTE: the stages are reset so sync and blank show idle levels for the first ticks.
                if (!n_rst) begin
                    for (int i = 0; i < DN; i++) stage_q[i] <= '0;
                end else if (advance) begin
                    stage_q[0] <= raw;
                    for (int i = 1; i < DN; i++) stage_q[i] <= stage_q[i-1];
                end
            end
            assign dly = stage_q[DN-1];
        end
    endgenerate

    assign pix_tick  = tick;
    assign line_end  = tick & h_wrap;
    assign frame_end = tick & h_wrap & (v_q == V_LAST);
    assign active    = raw.act;
    assign hPix      = raw.act ? h_q : '1;
    assign vPix      = raw.act ? v_q : '1;
    assign h_sync    = dly.hs ? HS_ON : ~HS_ON;
    assign v_sync    = dly.vs ? VS_ON : ~VS_ON;
    assign n_blank   = dly.act & en;
    assign n_sync    = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three geometries of vga_timing_gen compared every cycle against a
// frame-position model, plus hand-computed timing expectations for the default and 10x6 setups.
module tb_vga_timing_gen;

    localparam int NI = 3;
    localparam int C_CD [NI] = '{4, 1, 3};
    localparam int C_HA [NI] = '{640, 6, 12};
    localparam int C_HF [NI] = '{16, 1, 2};
    localparam int C_HS [NI] = '{96, 2, 3};
    localparam int C_HB [NI] = '{48, 1, 3};
    localparam int C_VA [NI] = '{480, 3, 4};
    localparam int C_VF [NI] = '{10, 1, 1};
    localparam int C_VS [NI] = '{2, 1, 2};
    localparam int C_VB [NI] = '{33, 1, 1};
    localparam int C_HP [NI] = '{0, 1, 0};
    localparam int C_VP [NI] = '{0, 1, 0};
    localparam int C_PD [NI] = '{2, 0, 3};

    logic clk = 1'b0, n_rst = 1'b0, en = 1'b0, restart = 1'b0;
    always #5 clk = ~clk;

    logic tk0, hs0, vs0, nb0, ns0, ac0, le0, fe0; logic [9:0] hp0; logic [9:0] vp0;
    logic tk1, hs1, vs1, nb1, ns1, ac1, le1, fe1; logic [3:0] hp1; logic [2:0] vp1;
    logic tk2, hs2, vs2, nb2, ns2, ac2, le2, fe2; logic [4:0] hp2; logic [2:0] vp2;

    vga_timing_gen u_d0 (
        .clk(clk), .n_rst(n_rst), .en(en), .restart(restart),
        .pix_tick(tk0), .h_sync(hs0), .v_sync(vs0), .n_blank(nb0), .n_sync(ns0),
        .hPix(hp0), .vPix(vp0), .active(ac0), .line_end(le0), .frame_end(fe0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .PIPE_DLY(0)
    ) u_d1 (
        .clk(clk), .n_rst(n_rst), .en(en), .restart(restart),
        .pix_tick(tk1), .h_sync(hs1), .v_sync(vs1), .n_blank(nb1), .n_sync(ns1),
        .hPix(hp1), .vPix(vp1), .active(ac1), .line_end(le1), .frame_end(fe1)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(12), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .PIPE_DLY(3)
    ) u_d2 (
        .clk(clk), .n_rst(n_rst), .en(en), .restart(restart),
        .pix_tick(tk2), .h_sync(hs2), .v_sync(vs2), .n_blank(nb2), .n_sync(ns2),
        .hPix(hp2), .vPix(vp2), .active(ac2), .line_end(le2), .frame_end(fe2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: linear frame position + tick history ----------------
    function automatic int htot(input int i);
        return C_HA[i] + C_HF[i] + C_HS[i] + C_HB[i];
    endfunction

    function automatic int vtot(input int i);
        return C_VA[i] + C_VF[i] + C_VS[i] + C_VB[i];
    endfunction

    // bit2 = in h sync, bit1 = in v sync, bit0 = visible
    function automatic int raw_at(input int i, input int p);
        int h, v, r;
        h = p % htot(i);
        v = p / htot(i);
        r = 0;
        if (h >= C_HA[i] + C_HF[i] && h < C_HA[i] + C_HF[i] + C_HS[i]) r += 4;
        if (v >= C_VA[i] + C_VF[i] && v < C_VA[i] + C_VF[i] + C_VS[i]) r += 2;
        if (h < C_HA[i] && v < C_VA[i]) r += 1;
        return r;
    endfunction

    bit m_live [NI] = '{0, 0, 0};
    int m_div  [NI] = '{0, 0, 0};
    int m_pos  [NI] = '{0, 0, 0};
    int m_nt   [NI] = '{0, 0, 0};
    int m_hist [NI][16];

    function automatic int delayed(input int i);
        if (!m_live[i]) return 0;
        if (C_PD[i] == 0) return raw_at(i, m_pos[i]);
        if (m_nt[i] < C_PD[i]) return 0;
        return m_hist[i][(m_nt[i] - C_PD[i]) % 16];
    endfunction

    task automatic model_step(input int i);
        if (!m_live[i]) begin
            m_live[i] = 1'b1;
        end else if (restart) begin
            m_div[i] = 0;
            m_pos[i] = 0;
        end else if (en) begin
            if (m_div[i] == C_CD[i] - 1) begin
                m_hist[i][m_nt[i] % 16] = raw_at(i, m_pos[i]);
                m_nt[i]++;
                m_pos[i] = (m_pos[i] + 1) % (htot(i) * vtot(i));
                m_div[i] = 0;
            end else begin
                m_div[i]++;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge n_rst);
        if (!n_rst) begin
            for (int i = 0; i < NI; i++) begin
                m_live[i] = 1'b0; m_div[i] = 0; m_pos[i] = 0; m_nt[i] = 0;
            end
        end else begin
            for (int i = 0; i < NI; i++) model_step(i);
        end
    end

    task automatic check_inst(input int i, input logic tk, input logic hs, input logic vs,
                              input logic nb, input logic ns, input logic ac, input logic le,
                              input logic fe, input int hp, input int vp);
        int h, v, d, ehp, evp, etk, ele, efe, evis;
        string p;
        p    = $sformatf("d%0d.", i);
        h    = m_pos[i] % htot(i);
        v    = m_pos[i] / htot(i);
        etk  = (en && m_live[i] && m_div[i] == C_CD[i] - 1) ? 1 : 0;
        evis = (m_live[i] && h < C_HA[i] && v < C_VA[i]) ? 1 : 0;
        ehp  = evis ? h : (1 << $clog2(htot(i))) - 1;
        evp  = evis ? v : (1 << $clog2(vtot(i))) - 1;
        ele  = (etk == 1 && h == htot(i) - 1) ? 1 : 0;
        efe  = (ele == 1 && v == vtot(i) - 1) ? 1 : 0;
        d    = delayed(i);
        check({p, "pix_tick"},  int'(tk), etk);
        check({p, "hPix"},      hp, ehp);
        check({p, "vPix"},      vp, evp);
        check({p, "active"},    int'(ac), evis);
        check({p, "line_end"},  int'(le), ele);
        check({p, "frame_end"}, int'(fe), efe);
        check({p, "h_sync"},    int'(hs), ((d & 4) != 0) ? C_HP[i] : 1 - C_HP[i]);
        check({p, "v_sync"},    int'(vs), ((d & 2) != 0) ? C_VP[i] : 1 - C_VP[i]);
        check({p, "n_blank"},   int'(nb), ((d & 1) != 0 && en) ? 1 : 0);
        check({p, "n_sync"},    int'(ns), 0);
    endtask

    initial forever begin
        @(negedge clk);
        check_inst(0, tk0, hs0, vs0, nb0, ns0, ac0, le0, fe0, int'(hp0), int'(vp0));
        check_inst(1, tk1, hs1, vs1, nb1, ns1, ac1, le1, fe1, int'(hp1), int'(vp1));
        check_inst(2, tk2, hs2, vs2, nb2, ns2, ac2, le2, fe2, int'(hp2), int'(vp2));
    end

    // ---------------- hand-computed timing expectations ----------------
    bit   lit = 1'b0, lit_clk = 1'b0;
    int   clkc = 0, tcnt = 0, t_h0 = -1, t_hsf = -1, t_le = -1, c_tick = -1, c_fe1 = -1;
    int   c_hs1 = -1, c_vs1 = -1;
    logic [9:0] prev_hp = 10'h3FF;
    logic prev_hs = 1'b1, prev_nb = 1'b0, prev_tk = 1'b0, prev_hs1 = 1'b0, prev_vs1 = 1'b0;

    initial forever begin
        @(negedge clk);
        clkc++;
        if (lit) begin
            if (hp0 == 10'd0 && prev_hp != 10'd0) t_h0 = tcnt;
            if (!hs0 && prev_hs && t_h0 >= 0) begin
                check("d0.hsync_start_ticks", tcnt - t_h0, 658);
                t_hsf = tcnt;
            end
            if (hs0 && !prev_hs && t_hsf >= 0) check("d0.hsync_width_ticks", tcnt - t_hsf, 96);
            if (le0) begin
                if (t_le >= 0) check("d0.line_len_ticks", tcnt - t_le, 800);
                t_le = tcnt;
            end
        end
        if (lit_clk) begin
            if (nb0 && !prev_nb && t_h0 >= 0) check("d0.nblank_lag_ticks", tcnt - t_h0, 2);
            if (tk0) begin
                if (c_tick >= 0) check("d0.tick_period_clks", clkc - c_tick, 4);
                c_tick = clkc;
            end
            if (prev_tk && prev_hp == 10'd639) check("d0.hPix_after_639", int'(hp0), 1023);
            if (fe1) begin
                if (c_fe1 >= 0) check("d1.frame_period_clks", clkc - c_fe1, 60);
                c_fe1 = clkc;
            end
            if (hs1 && !prev_hs1) c_hs1 = clkc;
            if (!hs1 && prev_hs1 && c_hs1 >= 0) check("d1.hsync_high_clks", clkc - c_hs1, 2);
            if (vs1 && !prev_vs1) c_vs1 = clkc;
            if (!vs1 && prev_vs1 && c_vs1 >= 0) check("d1.vsync_high_clks", clkc - c_vs1, 10);
        end
        prev_hp  = hp0;
        prev_hs  = hs0;
        prev_nb  = nb0;
        prev_tk  = tk0;
        prev_hs1 = hs1;
        prev_vs1 = vs1;
        if (tk0) tcnt++;
    end

    // ---------------- stimulus ----------------
    task automatic wait_hp(input int target, input logic want_tick, output bit found);
        found = 1'b0;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(posedge clk); #2;
            if (int'(hp0) == target && tk0 == want_tick) found = 1'b1;
        end
    endtask

    task automatic do_restart(input string name);
        restart = 1'b1;
        @(posedge clk); #2;
        restart = 1'b0;
        @(negedge clk);
        check({name, ".hPix"}, int'(hp0), 0);
        check({name, ".vPix"}, int'(vp0), 0);
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #2;
        check("rst.hPix",    int'(hp0), 1023);
        check("rst.vPix",    int'(vp0), 1023);
        check("rst.h_sync",  int'(hs0), 1);
        check("rst.v_sync1", int'(vs1), 0);
        check("rst.n_blank", int'(nb0), 0);
        check("rst.active",  int'(ac0), 0);
        check("rst.n_sync",  int'(ns0), 0);

        lit = 1'b1; lit_clk = 1'b1;
        en = 1'b1; n_rst = 1'b1;
        repeat (8000) @(posedge clk);
        #2;
        lit_clk = 1'b0;

        wait_hp(300, 1'b0, found);
        check("wait.hPix300", int'(found), 1);
        en = 1'b0;
        repeat (37) begin
            @(negedge clk);
            check("hold.hPix",    int'(hp0), 300);
            check("hold.n_blank", int'(nb0), 0);
        end
        @(posedge clk); #2;
        en = 1'b1;
        repeat (7000) @(posedge clk);
        #2;
        lit = 1'b0;

        wait_hp(500, 1'b0, found);
        check("wait.hPix500", int'(found), 1);
        do_restart("restart");
        wait_hp(500, 1'b1, found);
        check("wait.hPix500_tick", int'(found), 1);
        do_restart("restart_tick");

        for (int k = 0; k < 20000; k++) begin
            @(posedge clk); #2;
            en      = ($urandom_range(15) != 0);
            restart = ($urandom_range(299) == 0);
            if (k == 12000) begin
                en = 1'b1; restart = 1'b0; n_rst = 1'b0;
                #1;
                check("mrst.pix_tick1", int'(tk1), 0);
                check("mrst.line_end1", int'(le1), 0);
                check("mrst.hPix2",     int'(hp2), 31);
                check("mrst.h_sync1",   int'(hs1), 0);
                check("mrst.v_sync2",   int'(vs2), 1);
                check("mrst.n_blank0",  int'(nb0), 0);
                check("mrst.active1",   int'(ac1), 0);
                @(posedge clk); #2;
                n_rst = 1'b1;
            end
        end
        en = 1'b1; restart = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
